// File: rtl/vga_txt_pkg.sv
// Shared constants and state encoding for the VGA text-mode character fetch path.
// Geometry: 80x30 character cells of 8x16 pixels on a 640x480 active area.
package vga_txt_pkg;

   localparam int unsigned TXT_COLS = 80;
   localparam int unsigned TXT_ROWS = 30;
   localparam int unsigned FONT_H   = 16;
   localparam int unsigned CHAR_W   = 8;
   localparam int unsigned TXT_AW   = 12;
   localparam int unsigned FONT_AW  = 12;

   // First line number that is outside the active area.
   localparam logic [8:0] ACTIVE_LINES = 9'(TXT_ROWS * FONT_H);
   localparam logic [6:0] LAST_COL     = 7'(TXT_COLS - 1);

   typedef enum logic [1:0] {
      StIdle     = 2'd0,
      StPrefetch = 2'd1,
      StActive   = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/vga_txt_addr_gen.sv
// Text RAM address generator: addr = row*80 + col, built from shifts and adds.
// Ports:
//   row  - character row 0..29
//   col  - character column 0..79
//   addr - text RAM address 0..2399
module vga_txt_addr_gen
   import vga_txt_pkg::*;
(
   input  logic [4:0]        row,
   input  logic [6:0]        col,
   output logic [TXT_AW-1:0] addr
);

   logic [TXT_AW-1:0] row_w;
   logic [TXT_AW-1:0] col_w;

   always_comb begin
      row_w = {7'd0, row};
      col_w = {5'd0, col};
      // 80 = 64 + 16
      addr  = (row_w << 6) + (row_w << 4) + col_w;
   end

endmodule

// File: rtl/vga_char_fetch_ctrl.sv
// Character fetch sequencer for a text-mode VGA pipeline. For every active line it reads the
// 80 character codes of the current text row, looks up the matching glyph row in the font ROM
// and hands each byte to an external 8-bit pixel shift register, one byte per 8 pixel slots.
// Ports:
//   i_clk, i_rst_l          - clock, asynchronous active-low reset
//   i_pix_en                - pixel enable; nothing advances while it is low
//   i_line_start, i_line_y  - line start pulse and active line number (0..479)
//   o_txt_addr, o_txt_rd_h  - text RAM address / read strobe; i_txt_data one enabled cycle later
//   o_font_addr, o_font_rd_h- font ROM address / read strobe; i_font_data one enabled cycle later
//   o_sh_data, o_sh_ld_h    - glyph byte and load strobe for the shift register
//   o_sh_cs_h               - shift register select (pixel output forced to 0 when low)
//   o_busy_h                - high whenever a line is being fetched
module vga_char_fetch_ctrl
   import vga_txt_pkg::*;
(
   input  logic                i_clk,
   input  logic                i_rst_l,
   input  logic                i_pix_en,
   input  logic                i_line_start,
   input  logic [8:0]          i_line_y,
   output logic [TXT_AW-1:0]   o_txt_addr,
   output logic                o_txt_rd_h,
   input  logic [7:0]          i_txt_data,
   output logic [FONT_AW-1:0]  o_font_addr,
   output logic                o_font_rd_h,
   input  logic [7:0]          i_font_data,
   output logic [7:0]          o_sh_data,
   output logic                o_sh_ld_h,
   output logic                o_sh_cs_h,
   output logic                o_busy_h
);

   fetch_state_t state_q;
   logic [2:0]   phase_q;
   logic [6:0]   col_q;
   logic [8:0]   y_q;
   logic [7:0]   code_q;
   logic [7:0]   sh_data_q;

   logic              line_ok;
   logic              start_go;
   logic              step;
   logic              fetching;
   logic [4:0]        row_sel;
   logic [6:0]        col_sel;
   logic [TXT_AW-1:0] gen_addr;

   // The line_start cycle itself is phase 0 of the prefetch slot, so its text read is issued
   // directly from the pulse; this is what puts the first load exactly 7 enabled cycles later.
   always_comb begin
      line_ok  = i_line_y < ACTIVE_LINES;
      start_go = i_rst_l & i_pix_en & i_line_start & line_ok;
      // A line_start pulse aborts the slot in progress, so its strobes are suppressed.
      step     = i_pix_en & ~i_line_start;
      // Slot 79 of the active phase only shifts out the last byte; nothing is fetched.
      fetching = (state_q == StPrefetch) || ((state_q == StActive) && (col_q != LAST_COL));
      row_sel  = start_go ? i_line_y[8:4] : y_q[8:4];
      col_sel  = start_go ? 7'd0 : col_q + 7'd1;
   end

   vga_txt_addr_gen u_addr_gen (
      .row  (row_sel),
      .col  (col_sel),
      .addr (gen_addr)
   );

   always_comb begin
      o_txt_rd_h  = start_go |
                    (step && (state_q == StActive) && (col_q != LAST_COL) && (phase_q == 3'd0));
      o_txt_addr  = o_txt_rd_h ? gen_addr : '0;
      o_font_rd_h = step && fetching && (phase_q == 3'd2);
      o_font_addr = o_font_rd_h ? {code_q, y_q[3:0]} : '0;
      o_sh_ld_h   = step && fetching && (phase_q == 3'd7);
      o_sh_cs_h   = ((state_q == StPrefetch) && (phase_q == 3'd7)) || (state_q == StActive);
      o_busy_h    = state_q != StIdle;
      o_sh_data   = sh_data_q;
   end

   always_ff @(posedge i_clk or negedge i_rst_l) begin
      if (!i_rst_l) begin
         state_q   <= StIdle;
         phase_q   <= 3'd0;
         col_q     <= 7'd0;
         y_q       <= 9'd0;
         code_q    <= 8'd0;
         sh_data_q <= 8'd0;
      end else if (i_pix_en) begin
         if (i_line_start) begin
            col_q <= 7'd0;
            if (line_ok) begin
               state_q <= StPrefetch;
               y_q     <= i_line_y;
               phase_q <= 3'd1;
            end else begin
               state_q <= StIdle;
               phase_q <= 3'd0;
            end
         end else begin
            if (state_q != StIdle) begin
               phase_q <= phase_q + 3'd1;
            end
            if (fetching && (phase_q == 3'd1)) begin
               code_q <= i_txt_data;
            end
            if (fetching && (phase_q == 3'd3)) begin
               sh_data_q <= i_font_data;
            end
            if (phase_q == 3'd7) begin
               unique case (state_q)
                  StPrefetch: begin
                     state_q <= StActive;
                     col_q   <= 7'd0;
                  end
                  StActive: begin
                     if (col_q == LAST_COL) begin
                        state_q <= StIdle;
                        col_q   <= 7'd0;
                     end else begin
                        col_q <= col_q + 7'd1;
                     end
                  end
                  default: ;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_vga_char_fetch_ctrl.sv
`timescale 1ns/1ps
// Testbench for vga_char_fetch_ctrl: text RAM / font ROM models, an 8-bit shift register
// model and a per-line reference computed from character positions and glyph bits.
module tb_vga_char_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst_l;
   logic        pix_en;
   logic        line_start;
   logic [8:0]  line_y;
   logic [11:0] txt_addr;
   logic        txt_rd;
   logic [7:0]  txt_data;
   logic [11:0] font_addr;
   logic        font_rd;
   logic [7:0]  font_data;
   logic [7:0]  sh_data;
   logic        ld;
   logic        cs;
   logic        busy;

   logic [7:0] txt_ram  [0:4095];
   logic [7:0] font_rom [0:4095];

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   vga_char_fetch_ctrl dut (
      .i_clk        (clk),
      .i_rst_l      (rst_l),
      .i_pix_en     (pix_en),
      .i_line_start (line_start),
      .i_line_y     (line_y),
      .o_txt_addr   (txt_addr),
      .o_txt_rd_h   (txt_rd),
      .i_txt_data   (txt_data),
      .o_font_addr  (font_addr),
      .o_font_rd_h  (font_rd),
      .i_font_data  (font_data),
      .o_sh_data    (sh_data),
      .o_sh_ld_h    (ld),
      .o_sh_cs_h    (cs),
      .o_busy_h     (busy)
   );

   // Synchronous-read memories: data appears after the enabled edge that saw the strobe.
   always_ff @(posedge clk) begin
      if (pix_en && txt_rd)  txt_data  <= txt_ram[txt_addr];
      if (pix_en && font_rd) font_data <= font_rom[font_addr];
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [36:0] all_outs();
      return {txt_addr, txt_rd, font_addr, font_rd, sh_data, ld, cs, busy};
   endfunction

   task automatic fill_const(input logic [7:0] t, input logic [7:0] f);
      for (int i = 0; i < 4096; i++) begin
         txt_ram[i]  = t;
         font_rom[i] = f;
      end
   endtask

   task automatic fill_rand();
      for (int i = 0; i < 4096; i++) begin
         txt_ram[i]  = 8'($urandom);
         font_rom[i] = 8'($urandom);
      end
   endtask

   // Drives a line starting at enabled cycle k=0 and checks every enabled cycle up to stop_k
   // against the reference: text read at 8j, font read at 8j+2, load at 8j+7 (j<80),
   // select over 7..647, busy over 1..647, and 640 pixels out of a modelled shift register.
   // mode: 0 = enable always high, 1 = alternating, 2 = random 60 %.
   task automatic run_line(input string tag, input logic [8:0] y, input int mode,
                           input int stop_k, output logic [11:0] first_addr,
                           output logic [11:0] last_addr, output logic [11:0] last_faddr);
      int k, cyc, row, j;
      int e_txt, e_font, e_ld, e_cs, e_busy, e_idle, e_pix, n_ld, n_pix;
      logic en, exp_txt, exp_font, exp_ld, exp_cs, exp_busy, pixv;
      logic [11:0] exp_a;
      logic [7:0]  glyph;
      logic [7:0]  sr;
      row = int'(y[8:4]);
      k = 0; cyc = 0; sr = 8'd0;
      e_txt = 0; e_font = 0; e_ld = 0; e_cs = 0; e_busy = 0; e_idle = 0; e_pix = 0;
      n_ld = 0; n_pix = 0;
      first_addr = 12'hFFF; last_addr = 12'hFFF; last_faddr = 12'hFFF;
      while (k <= stop_k && cyc < 4000) begin
         @(negedge clk);
         if (k == 0 || mode == 0) en = 1'b1;
         else if (mode == 1)      en = (cyc % 2) == 1;
         else                     en = $urandom_range(0, 99) < 60;
         pix_en     = en;
         line_start = (k == 0);
         line_y     = y;
         #3;
         if (!en) begin
            if (txt_rd || font_rd || ld) e_idle++;
         end else begin
            exp_txt  = (k % 8 == 0) && (k < 640);
            exp_font = (k % 8 == 2) && (k < 640);
            exp_ld   = (k % 8 == 7) && (k < 640);
            exp_cs   = (k >= 7) && (k <= 647);
            exp_busy = (k >= 1) && (k <= 647);
            exp_a    = 12'(row * 80 + k / 8);
            if (txt_rd !== exp_txt || (exp_txt && txt_addr !== exp_a)) e_txt++;
            if (exp_txt && txt_rd) begin
               if (k == 0) first_addr = txt_addr;
               last_addr = txt_addr;
            end
            if (font_rd !== exp_font ||
                (exp_font && font_addr !== {txt_ram[exp_a], y[3:0]})) e_font++;
            if (exp_font && font_rd) last_faddr = font_addr;
            if (ld !== exp_ld) e_ld++;
            if (ld === 1'b1) n_ld++;
            if (k > 0 && cs !== exp_cs) e_cs++;
            if (k > 0 && busy !== exp_busy) e_busy++;
            if (k >= 8 && k <= 647) begin
               j     = k - 8;
               glyph = font_rom[{txt_ram[row * 80 + j / 8], y[3:0]}];
               pixv  = cs ? sr[7] : 1'b0;
               if (pixv !== glyph[7 - j % 8]) e_pix++;
               n_pix++;
            end
            sr = ld ? sh_data : {sr[6:0], 1'b0};
            k++;
         end
         cyc++;
      end
      line_start = 1'b0;
      chk({tag, "_timeout"}, 64'(k > stop_k), 64'(1));
      chk({tag, "_txt_rd"},  64'(e_txt),  64'(0));
      chk({tag, "_font_rd"}, 64'(e_font), 64'(0));
      chk({tag, "_ld"},      64'(e_ld),   64'(0));
      chk({tag, "_cs"},      64'(e_cs),   64'(0));
      chk({tag, "_busy"},    64'(e_busy), 64'(0));
      chk({tag, "_idle_strobes"}, 64'(e_idle), 64'(0));
      chk({tag, "_pixels"},  64'(e_pix),  64'(0));
      if (stop_k >= 648) begin
         chk({tag, "_n_loads"},  64'(n_ld),  64'(80));
         chk({tag, "_n_pixels"}, 64'(n_pix), 64'(640));
      end
   endtask

   // n enabled cycles; optional line_start on the first. Strobes must stay low throughout and
   // the block must be idle after the first cycle.
   task automatic quiet(input string tag, input int n, input logic [8:0] y, input bit pulse);
      int bad;
      bad = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         pix_en     = 1'b1;
         line_start = pulse && (i == 0);
         line_y     = y;
         #3;
         if (txt_rd || font_rd || ld) bad++;
         if (i > 0 && (cs || busy)) bad++;
      end
      line_start = 1'b0;
      chk(tag, 64'(bad), 64'(0));
   endtask

   logic [11:0] fa, la, lfa;
   logic [8:0]  ry;

   initial begin
      rst_l = 1'b0; pix_en = 1'b0; line_start = 1'b0; line_y = 9'd0;
      fill_const(8'h41, 8'hAA);
      #1;
      chk("reset_outputs", 64'(all_outs()), 64'(0));
      // A line start during reset must not leak onto the outputs.
      @(negedge clk);
      pix_en = 1'b1; line_start = 1'b1; line_y = 9'd5;
      #3;
      chk("reset_with_start", 64'(all_outs()), 64'(0));
      @(negedge clk);
      line_start = 1'b0;
      rst_l = 1'b1;
      quiet("post_reset_idle", 6, 9'd0, 1'b0);

      // Constant character 0x41 with glyph byte 0xAA on line 0.
      run_line("basic", 9'd0, 0, 650, fa, la, lfa);
      chk("basic_first_addr", 64'(fa), 64'(0));
      chk("basic_last_addr",  64'(la), 64'(79));
      chk("basic_sh_data",    64'(sh_data), 64'(8'hAA));
      chk("basic_font_addr",  64'(lfa), 64'({8'h41, 4'h0}));

      // Last active line: row 29, glyph row 15.
      fill_rand();
      run_line("y479", 9'd479, 0, 650, fa, la, lfa);
      chk("y479_first_addr", 64'(fa), 64'(2320));
      chk("y479_last_addr",  64'(la), 64'(2399));
      chk("y479_font_addr",  64'(lfa), 64'({txt_ram[2399], 4'hF}));
      chk("y479_sh_data",    64'(sh_data), 64'(font_rom[{txt_ram[2399], 4'hF}]));

      // Enable toggling 1-0-1 and random enable.
      run_line("en_toggle", 9'd0, 1, 650, fa, la, lfa);
      ry = 9'($urandom_range(0, 479));
      run_line("en_random", ry, 2, 650, fa, la, lfa);
      chk("en_random_first_addr", 64'(fa), 64'(int'(ry[8:4]) * 80));

      // Out-of-range line start in idle is ignored.
      quiet("y480_idle", 20, 9'd480, 1'b1);

      // Restart at column 40 (phase 3) with y=16.
      run_line("pre_abort", 9'd200, 0, 8 + 8 * 40 + 3, fa, la, lfa);
      run_line("restart", 9'd16, 0, 650, fa, la, lfa);
      chk("restart_first_addr", 64'(fa), 64'(80));

      // Abort to idle with an out-of-range line number.
      run_line("pre_abort_idle", 9'd300, 2, 100, fa, la, lfa);
      quiet("abort_idle", 10, 9'd480, 1'b1);

      // Asynchronous reset at column 37, phase 5, between clock edges.
      ry = 9'($urandom_range(0, 479));
      run_line("pre_reset", ry, 0, 8 + 8 * 37 + 5, fa, la, lfa);
      chk("pre_reset_busy", 64'(busy), 64'(1));
      #1 rst_l = 1'b0;
      #0.5;
      chk("async_reset", 64'(all_outs()), 64'(0));
      repeat (3) @(negedge clk);
      chk("reset_held", 64'(all_outs()), 64'(0));
      rst_l = 1'b1;
      quiet("reset_release_idle", 4, 9'd0, 1'b0);
      fill_rand();
      run_line("after_reset", ry, 0, 650, fa, la, lfa);

      // A couple of extra random lines.
      for (int t = 0; t < 2; t++) begin
         fill_rand();
         ry = 9'($urandom_range(0, 479));
         run_line("rand_line", ry, 2, 650, fa, la, lfa);
         chk("rand_line_last_addr", 64'(la), 64'(int'(ry[8:4]) * 80 + 79));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/vga_char_fetch_ctrl.md
VGA_CHAR_FETCH_CTRL -- requirements
Module: vga_char_fetch_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: i_clk, i_rst_l.
REQ-002 i_clk  input  1  system clock; all state updates on the rising edge.
REQ-003 i_rst_l  input  1  asynchronous, active-low reset.
REQ-004 i_pix_en  input  1  pixel enable; sequencing advances only in cycles where it is 1 (an "enabled cycle").
REQ-005 i_line_start  input  1  one-enabled-cycle pulse, 8 enabled cycles before the first active pixel of a line.
REQ-006 i_line_y  input  9  active line number, 0..479; sampled with i_line_start.
REQ-007 o_txt_addr  output  12  text RAM address, row*80+col.
REQ-008 o_txt_rd_h  output  1  text RAM read strobe.
REQ-009 i_txt_data  input  8  character code; valid on the enabled cycle after o_txt_rd_h.
REQ-010 o_font_addr  output  12  font ROM address {code[7:0], line_y[3:0]}.
REQ-011 o_font_rd_h  output  1  font ROM read strobe.
REQ-012 i_font_data  input  8  glyph row; valid on the enabled cycle after o_font_rd_h.
REQ-013 o_sh_data  output  8  byte for the 8-bit pixel shift register.
REQ-014 o_sh_ld_h  output  1  shift-register load strobe.
REQ-015 o_sh_cs_h  output  1  shift-register chip select; 0 forces pixel output to 0.
REQ-016 o_busy_h  output  1  1 in any state other than IDLE.

Function
REQ-017 States SHALL be IDLE, PREFETCH and ACTIVE, with a 3-bit phase counter (0..7) and a 7-bit column counter (0..79), both advancing only on enabled cycles.
REQ-018 In IDLE, i_line_start with i_line_y<480 SHALL latch y, clear phase and column, and enter PREFETCH; if i_line_y>=480, the pulse SHALL be ignored.
REQ-019 Per 8-phase slot fetching column c:
- phase 0: o_txt_rd_h=1, o_txt_addr=y[8:4]*80+c
- phase 1: capture i_txt_data
- phase 2: o_font_rd_h=1, o_font_addr={code, y[3:0]}
- phase 3: capture i_font_data into o_sh_data
- phase 7: o_sh_ld_h=1
Strobes SHALL be one enabled cycle wide.
REQ-020 PREFETCH SHALL fetch column 0. At phase 7 it SHALL assert o_sh_ld_h and o_sh_cs_h, then enter ACTIVE with column=0.
REQ-021 In ACTIVE slot c:
- for c<79, it SHALL fetch column c+1 and load at phase 7;
- for c=79, it SHALL issue no reads and no load.
REQ-022 With line_start at enabled cycle T, the load edges SHALL be T+7+8k (k=0..79), and o_sh_cs_h SHALL be 1 from T+7 through T+647 inclusive.
REQ-023 After phase 7 of slot 79, the block SHALL return to IDLE, with o_sh_cs_h=0 in the next cycle.
REQ-024 i_line_start in PREFETCH or ACTIVE SHALL abort the line:
- with y<480, restart PREFETCH with the new y;
- otherwise go to IDLE, and o_sh_cs_h SHALL drop in the next cycle.
REQ-025 When i_pix_en=0, all state SHALL hold and all read/load strobes SHALL be 0.
REQ-026 Address arithmetic SHALL be 12-bit unsigned with shift-add (row<<6 + row<<4 + col) and no multiplier; the maximum value is 2399.
REQ-027 o_sh_data SHALL hold its value between captures.

Reset
REQ-028 While i_rst_l=0, the block SHALL be in IDLE, counters 0, and all outputs 0, including o_sh_data.
REQ-029 Reset asserted mid-line SHALL take effect immediately (asynchronously), with o_sh_cs_h low.
REQ-030 After reset release, the block SHALL wait in IDLE for i_line_start.

Structure
REQ-031 Shared package vga_txt_pkg SHALL hold TXT_COLS=80, TXT_ROWS=30, FONT_H=16, CHAR_W=8, TXT_AW=12, FONT_AW=12, and the state encoding.
REQ-032 The row*80+col address generator SHALL be the combinational sub-module vga_txt_addr_gen.
REQ-033 The pixel shift register SHALL be instantiated by the parent, not inside this block.

Verification
REQ-034 Reset, then i_pix_en=1 and line_start at T with y=0; text RAM all 0x41, font byte 0xAA -> loads at T+7, T+15, ... T+639 (80 loads); o_sh_data=0xAA; cs high T+7..T+647.
REQ-035 y=479 -> first o_txt_addr=2320; column-79 fetch address=2399; o_font_addr={code,4'hF}.
REQ-036 i_pix_en toggling 1-0-1 -> cycle-exact equivalence to REQ-034 counted in enabled cycles; no strobes while enable is 0.
REQ-037 line_start with y=480 -> stays IDLE, no strobes; line_start at column 40 with y=16 -> restart with first address 80.
REQ-038 Reset asserted at column 37, phase 5 -> all outputs 0 immediately; next line runs normally.
REQ-039 Bench model: a real 8-bit shift register plus RAM/ROM models -> 640 output pixels match the reference glyph bit order, MSB first.
